// File: rtl/lcd_driver.sv
// lcd_driver: HSYNC/VSYNC/DE timing generator for an RGB panel, with one-cycle-early pixel request.
// Rev 1.0
`default_nettype none

module lcd_driver #(
  parameter logic [10:0] H_SYNC  = 11'd128,
  parameter logic [10:0] H_BACK  = 11'd88,
  parameter logic [10:0] H_DISP  = 11'd800,
  parameter logic [10:0] H_FRONT = 11'd40,
  parameter logic [10:0] H_TOTAL = 11'd1056,
  parameter logic [10:0] V_SYNC  = 11'd2,
  parameter logic [10:0] V_BACK  = 11'd33,
  parameter logic [10:0] V_DISP  = 11'd480,
  parameter logic [10:0] V_FRONT = 11'd10,
  parameter logic [10:0] V_TOTAL = 11'd525
) (
  input  logic        lcd_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        lcd_rst,
  output logic        lcd_pclk
);

  localparam logic [10:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [10:0] H_ACT_END   = H_ACT_START + H_DISP;
  localparam logic [10:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [10:0] V_ACT_END   = V_ACT_START + V_DISP;
  // The porch sum defines the period if it ever disagrees with the *_TOTAL value.
  localparam logic [10:0] H_LAST = (H_ACT_END + H_FRONT == H_TOTAL) ? H_TOTAL - 11'd1
                                                                    : H_ACT_END + H_FRONT - 11'd1;
  localparam logic [10:0] V_LAST = (V_ACT_END + V_FRONT == V_TOTAL) ? V_TOTAL - 11'd1
                                                                    : V_ACT_END + V_FRONT - 11'd1;

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_act;
  logic        v_act;
  logic        data_req;

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) lcd_bl <= 1'b0;
    else            lcd_bl <= 1'b1;
  end

  assign lcd_hs = (h_cnt >= H_SYNC);
  assign lcd_vs = (v_cnt >= V_SYNC);
  assign h_act  = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
  assign v_act  = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
  assign lcd_de = h_act && v_act;

  // Request runs one column ahead so the registered downstream stage lines up with DE.
  assign data_req   = v_act && (h_cnt >= H_ACT_START - 11'd1) && (h_cnt < H_ACT_END - 11'd1);
  assign pixel_xpos = data_req ? h_cnt - (H_ACT_START - 11'd1) : '0;
  assign pixel_ypos = data_req ? v_cnt - V_ACT_START : '0;

  assign lcd_rgb  = lcd_de ? pixel_data : 16'd0;
  assign lcd_rst  = sys_rst_n;
  assign lcd_pclk = lcd_clk;

endmodule

`default_nettype wire

// File: tb/tb_lcd_driver.sv
// tb_lcd_driver: table vectors on a full-size instance, per-cycle scoreboard on a reduced-timing instance.
`default_nettype none

module tb_lcd_driver;

  // Reduced timing for the second instance so whole frames fit in a short run.
  localparam int SHS = 4, SHB = 3, SHD = 8, SHF = 2, SHT = 17;
  localparam int SVS = 2, SVB = 3, SVD = 5, SVF = 2, SVT = 12;
  localparam int SFRAME = SHT * SVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d_n, rst_s_n;
  logic [15:0] pd_d, pd_s;
  logic [10:0] x_d, y_d, x_s, y_s;
  logic        hs_d, vs_d, de_d, bl_d, lrst_d, pclk_d;
  logic        hs_s, vs_s, de_s, bl_s, lrst_s, pclk_s;
  logic [15:0] rgb_d, rgb_s;

  lcd_driver dut_d (
    .lcd_clk(clk), .sys_rst_n(rst_d_n), .pixel_data(pd_d),
    .pixel_xpos(x_d), .pixel_ypos(y_d), .lcd_hs(hs_d), .lcd_vs(vs_d), .lcd_de(de_d),
    .lcd_rgb(rgb_d), .lcd_bl(bl_d), .lcd_rst(lrst_d), .lcd_pclk(pclk_d)
  );

  lcd_driver #(
    .H_SYNC(11'd4), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2), .H_TOTAL(11'd17),
    .V_SYNC(11'd2), .V_BACK(11'd3), .V_DISP(11'd5), .V_FRONT(11'd2), .V_TOTAL(11'd12)
  ) dut_s (
    .lcd_clk(clk), .sys_rst_n(rst_s_n), .pixel_data(pd_s),
    .pixel_xpos(x_s), .pixel_ypos(y_s), .lcd_hs(hs_s), .lcd_vs(vs_s), .lcd_de(de_s),
    .lcd_rgb(rgb_s), .lcd_bl(bl_s), .lcd_rst(lrst_s), .lcd_pclk(pclk_s)
  );

  // Downstream pattern stage models: return the requested column one cycle later.
  always @(posedge clk or negedge rst_d_n)
    if (!rst_d_n) pd_d <= 16'd0;
    else          pd_d <= {5'd0, x_d};

  always @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) pd_s <= 16'd0;
    else          pd_s <= 16'hF800 | {5'd0, x_s};

  typedef logic [42:0] obs_t;  // {rst, hs, vs, de, bl, x, y, rgb}
  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  int   compared = 0;
  int   mismatched = 0;
  obs_t sb_q[$];
  vec_t tbl[15];

  function automatic obs_t mk(logic r, logic hs, logic vs, logic de, logic bl,
                              int x, int y, int rgb);
    logic [10:0] xv, yv;
    logic [15:0] cv;
    xv = x[10:0];
    yv = y[10:0];
    cv = rgb[15:0];
    return {r, hs, vs, de, bl, xv, yv, cv};
  endfunction

  function automatic logic s_req(int k);
    int h, v;
    h = k % SHT;
    v = (k / SHT) % SVT;
    return (v >= SVS + SVB) && (v < SVS + SVB + SVD) &&
           (h >= SHS + SHB - 1) && (h < SHS + SHB + SHD - 1);
  endfunction

  function automatic int s_x(int k);
    return s_req(k) ? (k % SHT) - (SHS + SHB - 1) : 0;
  endfunction

  // Expected small-instance outputs k clock edges after reset release.
  function automatic obs_t exp_s(int k);
    int  h, v, y, rgb;
    logic de;
    h   = k % SHT;
    v   = (k / SHT) % SVT;
    de  = (h >= SHS + SHB) && (h < SHS + SHB + SHD) && (v >= SVS + SVB) && (v < SVS + SVB + SVD);
    y   = s_req(k) ? v - (SVS + SVB) : 0;
    rgb = de ? (16'hF800 | s_x(k - 1)) : 0;
    return mk(1'b1, h >= SHS, v >= SVS, de, k >= 1, s_x(k), y, rgb);
  endfunction

  function automatic obs_t obs_d();
    return {lrst_d, hs_d, vs_d, de_d, bl_d, x_d, y_d, rgb_d};
  endfunction

  function automatic obs_t obs_s();
    return {lrst_s, hs_s, vs_s, de_s, bl_s, x_s, y_s, rgb_s};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 30)
        $display("FAIL %s: got {rst,hs,vs,de,bl,x,y,rgb}=%h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      if (mismatched <= 30) $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  int ks;
  task automatic step_s(input string name);
    @(posedge clk);
    ks++;
    sb_q.push_back(exp_s(ks));
    @(negedge clk);
    check(name, obs_s(), sb_q.pop_front());
  endtask

  initial begin
    int   kd;
    int   fall_k;
    logic prev_vs;

    // k, {rst, hs, vs, de, bl, xpos, ypos, rgb} for the full-size panel
    tbl[0]  = '{0,     mk(1, 0, 0, 0, 0, 0,   0, 0)};
    tbl[1]  = '{1,     mk(1, 0, 0, 0, 1, 0,   0, 0)};
    tbl[2]  = '{127,   mk(1, 0, 0, 0, 1, 0,   0, 0)};
    tbl[3]  = '{128,   mk(1, 1, 0, 0, 1, 0,   0, 0)};
    tbl[4]  = '{1055,  mk(1, 1, 0, 0, 1, 0,   0, 0)};
    tbl[5]  = '{1056,  mk(1, 0, 0, 0, 1, 0,   0, 0)};
    tbl[6]  = '{2112,  mk(1, 0, 1, 0, 1, 0,   0, 0)};
    tbl[7]  = '{36119, mk(1, 1, 1, 0, 1, 0,   0, 0)};
    tbl[8]  = '{37175, mk(1, 1, 1, 0, 1, 0,   0, 0)};
    tbl[9]  = '{37176, mk(1, 1, 1, 1, 1, 1,   0, 0)};
    tbl[10] = '{37560, mk(1, 1, 1, 1, 1, 385, 0, 384)};
    tbl[11] = '{37974, mk(1, 1, 1, 1, 1, 799, 0, 798)};
    tbl[12] = '{37975, mk(1, 1, 1, 1, 1, 0,   0, 799)};
    tbl[13] = '{37976, mk(1, 1, 1, 0, 1, 0,   0, 0)};
    tbl[14] = '{38516, mk(1, 1, 1, 1, 1, 285, 1, 284)};

    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_full", obs_d(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    check("reset_small", obs_s(), mk(0, 0, 0, 0, 0, 0, 0, 0));

    rst_d_n = 1'b1;
    kd = 0;
    for (int i = 0; i < 15; i++) begin
      while (kd < tbl[i].k) begin
        @(posedge clk);
        kd++;
      end
      #2;
      check($sformatf("full_vec%0d", i), obs_d(), tbl[i].exp);
    end
    @(negedge clk);
    #1 check_int("pclk_low", int'(pclk_d), 0);
    @(posedge clk);
    #1 check_int("pclk_high", int'(pclk_d), 1);

    // Small instance: three frames cycle by cycle, then a mid-frame reset.
    @(negedge clk);
    rst_s_n = 1'b1;
    ks = 0;
    sb_q.push_back(exp_s(0));
    #1 check("small_k0", obs_s(), sb_q.pop_front());
    while (ks < 2 * SFRAME + 6 * SHT + 10) step_s("small_cycle");

    @(posedge clk);
    #2 rst_s_n = 1'b0;
    #1 check("async_reset", obs_s(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", obs_s(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_s_n = 1'b1;
    ks = 0;
    sb_q.push_back(exp_s(0));
    #1 check("restart_k0", obs_s(), sb_q.pop_front());

    fall_k  = -1;
    prev_vs = vs_s;
    while (ks < SFRAME + 4) begin
      step_s("restart_cycle");
      if (prev_vs && !vs_s && fall_k < 0) fall_k = ks;
      prev_vs = vs_s;
    end
    check_int("vs_fall_after_restart", fall_k, SFRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
